lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
- Sits in the decode stage, between the first and second pipeline registers.
- Expands each multiple load/store (LM/SM) into a series of single-register load/store micro-ops, one per set bit of the register list.
- Drives the first_multiple marker that travels down the pipeline with each micro-op.
- Throttles fetch through a ready handshake while the expansion runs; all other instructions pass through with one cycle of latency.

Parameters:
- WORD, 16, instruction width.
- NREGS, 8, register-list width and register count.
- IMM_W, 6, immediate field width of the emitted micro-op.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_ir holds a valid instruction.
- in_ir  in  16  instruction from the first pipeline register.
- in_ready  out  1  sequencer can accept in_ir this cycle; upstream holds PC and IR while low.
- hold  in  1  downstream stall; freeze all state and outputs.
- flush  in  1  branch/jump squash; abort the current expansion.
- out_valid  out  1  out_ir is a real instruction (0 = bubble).
- out_ir  out  16  instruction or micro-op sent to the second pipeline register.
- first_multiple  out  1  out_ir is the first micro-op of an LM/SM.
- last_multiple  out  1  out_ir is the final micro-op of an LM/SM.
- busy  out  1  expansion in progress (state SEQ).

Behaviour:
- Reset values while reset=0: out_valid=0, out_ir=16'h0000, first_multiple=0, last_multiple=0, busy=0, state=IDLE, remaining list=0, in_ready=0.
- Instruction fields:
  - opcode = in_ir[15:12]; LM=4'b0110, SM=4'b0111.
  - base RA = in_ir[11:9]; list = in_ir[7:0], where bit i selects Ri.
- Micro-op format: {op, Ri, RA, imm6}.
  - op = LW 4'b0100 for LM, SW 4'b0101 for SM.
  - imm6 = zero-extended rank of Ri, i.e. the number of list bits set below bit i.
- in_ready = (state==IDLE) & ~hold & reset.
- Accept: an instruction is accepted on a rising edge where in_valid & in_ready.
- Priority on each edge: reset > flush > hold > normal operation.
- flush=1:
  - state goes to IDLE, remaining list clears.
  - Next cycle: out_valid=0, out_ir=0, first_multiple=0, last_multiple=0.
  - Any instruction presented in the same cycle is discarded.
- hold=1 (no flush): every register keeps its value; no micro-op is consumed.
- IDLE, accepting a non-LM/SM instruction: out_ir<=in_ir, out_valid<=1, first_multiple<=0, last_multiple<=0.
- IDLE, accepting an LM/SM with list==0:
  - Treated as NOP: out_valid<=0, out_ir<=0.
  - State stays IDLE.
- IDLE, accepting an LM/SM with list!=0:
  - Capture opcode, RA and list.
  - Emit the first micro-op on the same edge, with first_multiple<=1.
  - Clear its bit. If the remaining list is empty, set last_multiple<=1 and stay IDLE; otherwise go to SEQ.
- SEQ, on each un-held edge:
  - Emit the next micro-op with first_multiple<=0.
  - Clear its bit; when it was the last one, set last_multiple<=1 and go to IDLE.
- Emission order:
  - Ascending register index.
  - Exception for LM with bit RA set: RA is deferred and emitted last, keeping its own rank as offset, so the base register is not overwritten before later addresses use it.
  - SM never defers.
- Latency and throughput:
  - A list with N bits emits its micro-ops on edges T..T+N-1 after acceptance at edge T, visible cycles T+1..T+N.
  - in_ready rises during the cycle showing the last micro-op, so back-to-back LM/SM has no bubble.
- No holes: out_valid=0 only after reset, a flush, an empty-list LM/SM, or a cycle without an accept.
- Reset asserted mid-sequence: all outputs drop to their reset values immediately, without waiting for a clock.

Decomposition:
- Shared package (processor-wide):
  - Opcode constants OP_LM, OP_SM, OP_LW, OP_SW.
  - NOP_WORD=16'h0000.
  - Sequencer state enum {IDLE, SEQ}.
- One natural sub-module, reglist_pick:
  - Combinational lowest-set-bit picker over the remaining list with an optional masked deferred index.
  - Outputs pick index, pick-valid and remaining-after-pick.
- Rank (popcount below i) is computed in the parent from the captured original list.

Test Plan:
- Pass-through: ADD 16'h0050 accepted → next cycle out_ir=16'h0050, out_valid=1, first_multiple=0, in_ready stays 1.
- LM 16'h6215 (RA=R1, list 8'b00010101) → out_ir 16'h4040, 16'h4441, 16'h4842 on 3 consecutive cycles.
  - first_multiple=1 only on 16'h4040; last_multiple=1 only on 16'h4842.
  - in_ready=0 on the cycle showing 16'h4040 and on the cycle that shows 16'h4441.
- LM base-deferral: 16'h640E (RA=R2, list R1,R2,R3) → 16'h4280, 16'h4682, 16'h4481 in that order.
- SM with hold: 16'h7081 (RA=R0, list R0,R7) with hold=1 for one cycle after the first micro-op → 16'h5000 shown 2 cycles, then 16'h5E01; base not deferred.
- Flush: apply flush on the cycle the first micro-op of 16'h6215 is visible → next cycle out_valid=0, out_ir=0, busy=0, in_ready=1; no 16'h4441 ever appears.
- Empty list and reset:
  - 16'h6200 accepted → out_valid=0 next cycle, busy=0.
  - reset=0 asynchronously during the 16'h6215 sequence → all outputs 0 before the next edge.
  - Deasserting reset restarts in IDLE.

Source files
------------

// File: rtl/lm_sm_sequencer_pkg.sv
// Processor-wide decode constants and the LM/SM sequencer state type.
package lm_sm_sequencer_pkg;

   localparam logic [3:0]  OP_LM    = 4'b0110;
   localparam logic [3:0]  OP_SM    = 4'b0111;
   localparam logic [3:0]  OP_LW    = 4'b0100;
   localparam logic [3:0]  OP_SW    = 4'b0101;
   localparam logic [15:0] NOP_WORD = 16'h0000;

   typedef enum logic {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } seqState_t;

   // True for the two multiple-register opcodes that need expansion.
   function automatic logic isMultiple(input logic [3:0] opc);
      return (opc == OP_LM) || (opc == OP_SM);
   endfunction

endpackage

// File: rtl/lm_sm_sequencer_reglist_pick.sv
// Lowest-set-bit picker over a register list. When deferEn is set, the
// register at deferIdx is skipped while any other bit remains, so it is
// picked last.
module lm_sm_sequencer_reglist_pick #(
   parameter int NREGS = 8,
   parameter int IDXW  = $clog2(NREGS)
) (
   input  logic [NREGS-1:0] list,
   input  logic             deferEn,
   input  logic [IDXW-1:0]  deferIdx,
   output logic [IDXW-1:0]  pickIdx,
   output logic             pickValid,
   output logic [NREGS-1:0] remaining
);

   logic [NREGS-1:0] deferMaskS;
   logic [NREGS-1:0] maskedS;
   logic [NREGS-1:0] searchS;
   logic [NREGS-1:0] pickMaskS;

   // Choose the lowest eligible bit, falling back to the deferred one.
   always_comb begin
      deferMaskS           = '0;
      deferMaskS[deferIdx] = deferEn;
      maskedS              = list & ~deferMaskS;
      if (maskedS != '0) begin
         searchS = maskedS;
      end else begin
         searchS = list;
      end
      pickIdx = '0;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (searchS[i]) begin
            pickIdx = i[IDXW-1:0];
         end else begin
            pickIdx = pickIdx;
         end
      end
      pickValid          = (list != '0);
      pickMaskS          = '0;
      pickMaskS[pickIdx] = pickValid;
      remaining          = list & ~pickMaskS;
   end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Decode-stage LM/SM expander: turns a multiple load/store into one
// LW/SW micro-op per listed register and passes everything else through
// with one cycle of latency.
module lm_sm_sequencer
   import lm_sm_sequencer_pkg::*;
#(
   parameter int WORD  = 16,
   parameter int NREGS = 8,
   parameter int IMM_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [WORD-1:0] in_ir,
   output logic            in_ready,
   input  logic            hold,
   input  logic            flush,
   output logic            out_valid,
   output logic [WORD-1:0] out_ir,
   output logic            first_multiple,
   output logic            last_multiple,
   output logic            busy
);

   localparam int IDXW = $clog2(NREGS);

   seqState_t        stateR, stateS;
   logic [NREGS-1:0] listR, listS;
   logic [NREGS-1:0] origListR, origListS;
   logic [3:0]       opR, opS;
   logic [IDXW-1:0]  raR, raS;
   logic             deferR, deferS;
   logic             outValidR, outValidS;
   logic [WORD-1:0]  outIrR, outIrS;
   logic             firstR, firstS;
   logic             lastR, lastS;

   logic             idleS;
   logic [3:0]       inOpS;
   logic [IDXW-1:0]  inRaS;
   logic [NREGS-1:0] inListS;
   logic             inIsLmS;
   logic             deferInS;
   logic [NREGS-1:0] pickListS;
   logic [NREGS-1:0] rankListS;
   logic             deferEnS;
   logic [IDXW-1:0]  deferIdxS;
   logic [3:0]       uOpS;
   logic [IDXW-1:0]  uRaS;
   logic [IDXW-1:0]  pickIdxS;
   logic             pickValidS;
   logic [NREGS-1:0] remainingS;
   logic [IMM_W-1:0] rankS;
   logic [WORD-1:0]  microOpS;
   logic             unusedIrBit;

   assign idleS       = (stateR == IDLE);
   assign inOpS       = in_ir[15:12];
   assign inRaS       = in_ir[11:9];
   assign inListS     = in_ir[7:0];
   assign unusedIrBit = in_ir[8];
   assign inIsLmS     = (inOpS == OP_LM);
   assign deferInS    = inIsLmS & inListS[inRaS];

   assign in_ready       = idleS & ~hold & reset;
   assign out_valid      = outValidR;
   assign out_ir         = outIrR;
   assign first_multiple = firstR;
   assign last_multiple  = lastR;
   assign busy           = (stateR == SEQ);

   // In IDLE the first micro-op comes straight from in_ir; in SEQ from the captured copy.
   always_comb begin
      if (idleS) begin
         pickListS = inListS;
         rankListS = inListS;
         deferEnS  = deferInS;
         deferIdxS = inRaS;
         uRaS      = inRaS;
         if (inIsLmS) begin
            uOpS = OP_LW;
         end else begin
            uOpS = OP_SW;
         end
      end else begin
         pickListS = listR;
         rankListS = origListR;
         deferEnS  = deferR;
         deferIdxS = raR;
         uRaS      = raR;
         uOpS      = opR;
      end
   end

   lm_sm_sequencer_reglist_pick #(
      .NREGS (NREGS),
      .IDXW  (IDXW)
   ) uPick (
      .list      (pickListS),
      .deferEn   (deferEnS),
      .deferIdx  (deferIdxS),
      .pickIdx   (pickIdxS),
      .pickValid (pickValidS),
      .remaining (remainingS)
   );

   // Offset of the picked register: number of original list bits below it.
   always_comb begin
      rankS = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (i < int'(pickIdxS)) begin
            rankS = rankS + {{(IMM_W-1){1'b0}}, rankListS[i]};
         end else begin
            rankS = rankS;
         end
      end
      microOpS = {uOpS, pickIdxS, uRaS, rankS};
   end

   // Next-state and next-output decision: flush beats hold beats normal flow.
   always_comb begin
      stateS    = stateR;
      listS     = listR;
      origListS = origListR;
      opS       = opR;
      raS       = raR;
      deferS    = deferR;
      outValidS = outValidR;
      outIrS    = outIrR;
      firstS    = firstR;
      lastS     = lastR;
      if (flush) begin
         stateS    = IDLE;
         listS     = '0;
         outValidS = 1'b0;
         outIrS    = NOP_WORD;
         firstS    = 1'b0;
         lastS     = 1'b0;
      end else if (hold) begin
         stateS = stateR;
      end else begin
         case (stateR)
            IDLE: begin
               if (!in_valid) begin
                  outValidS = 1'b0;
                  outIrS    = NOP_WORD;
                  firstS    = 1'b0;
                  lastS     = 1'b0;
               end else if (!isMultiple(inOpS)) begin
                  outValidS = 1'b1;
                  outIrS    = in_ir;
                  firstS    = 1'b0;
                  lastS     = 1'b0;
               end else if (!pickValidS) begin
                  outValidS = 1'b0;
                  outIrS    = NOP_WORD;
                  firstS    = 1'b0;
                  lastS     = 1'b0;
               end else begin
                  origListS = inListS;
                  opS       = uOpS;
                  raS       = inRaS;
                  deferS    = deferInS;
                  listS     = remainingS;
                  outValidS = 1'b1;
                  outIrS    = microOpS;
                  firstS    = 1'b1;
                  lastS     = (remainingS == '0);
                  if (remainingS == '0) begin
                     stateS = IDLE;
                  end else begin
                     stateS = SEQ;
                  end
               end
            end
            SEQ: begin
               listS     = remainingS;
               outValidS = 1'b1;
               outIrS    = microOpS;
               firstS    = 1'b0;
               lastS     = (remainingS == '0);
               if (remainingS == '0) begin
                  stateS = IDLE;
               end else begin
                  stateS = SEQ;
               end
            end
            default: begin
               stateS    = IDLE;
               listS     = '0;
               outValidS = 1'b0;
               outIrS    = NOP_WORD;
               firstS    = 1'b0;
               lastS     = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset clears outputs without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateR    <= IDLE;
         listR     <= '0;
         origListR <= '0;
         opR       <= 4'b0000;
         raR       <= '0;
         deferR    <= 1'b0;
         outValidR <= 1'b0;
         outIrR    <= NOP_WORD;
         firstR    <= 1'b0;
         lastR     <= 1'b0;
      end else begin
         stateR    <= stateS;
         listR     <= listS;
         origListR <= origListS;
         opR       <= opS;
         raR       <= raS;
         deferR    <= deferS;
         outValidR <= outValidS;
         outIrR    <= outIrS;
         firstR    <= firstS;
         lastR     <= lastS;
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer: hand-computed micro-op sequences.
module tb_lm_sm_sequencer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [15:0] in_ir;
   logic        in_ready;
   logic        hold;
   logic        flush;
   logic        out_valid;
   logic [15:0] out_ir;
   logic        first_multiple;
   logic        last_multiple;
   logic        busy;

   int passCnt  = 0;
   int totalCnt = 0;

   lm_sm_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ir          (in_ir),
      .in_ready       (in_ready),
      .hold           (hold),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ir         (out_ir),
      .first_multiple (first_multiple),
      .last_multiple  (last_multiple),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; in_ir = 16'h0000; hold = 1'b0; flush = 1'b0;
      step(); step();
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passCnt++;
      totalCnt++; if (out_ir !== 16'h0000) $display("FAIL reset_ir got %h want 0000", out_ir); else passCnt++;
      totalCnt++; if ({first_multiple, last_multiple, busy} !== 3'b000) $display("FAIL reset_flags got %b want 000", {first_multiple, last_multiple, busy}); else passCnt++;
      totalCnt++; if (in_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", in_ready); else passCnt++;
      reset = 1'b1;
      step();
      totalCnt++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", in_ready); else passCnt++;
   endtask

   task automatic test_passthrough();
      in_valid = 1'b1; in_ir = 16'h0050;
      step();
      in_valid = 1'b0;
      totalCnt++; if ({out_valid, out_ir} !== {1'b1, 16'h0050}) $display("FAIL pass_out got %b/%h want 1/0050", out_valid, out_ir); else passCnt++;
      totalCnt++; if ({first_multiple, in_ready} !== 2'b01) $display("FAIL pass_flags got %b want 01", {first_multiple, in_ready}); else passCnt++;
      step();
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL pass_bubble got %b want 0", out_valid); else passCnt++;
   endtask

   task automatic test_lm();
      in_valid = 1'b1; in_ir = 16'h6215;
      step();
      in_valid = 1'b0;
      totalCnt++; if (out_ir !== 16'h4040) $display("FAIL lm_op0 got %h want 4040", out_ir); else passCnt++;
      totalCnt++; if ({out_valid, first_multiple, last_multiple, in_ready, busy} !== 5'b11001) $display("FAIL lm_flags0 got %b want 11001", {out_valid, first_multiple, last_multiple, in_ready, busy}); else passCnt++;
      step();
      totalCnt++; if (out_ir !== 16'h4441) $display("FAIL lm_op1 got %h want 4441", out_ir); else passCnt++;
      totalCnt++; if ({out_valid, first_multiple, last_multiple, in_ready} !== 4'b1000) $display("FAIL lm_flags1 got %b want 1000", {out_valid, first_multiple, last_multiple, in_ready}); else passCnt++;
      step();
      totalCnt++; if (out_ir !== 16'h4842) $display("FAIL lm_op2 got %h want 4842", out_ir); else passCnt++;
      totalCnt++; if ({out_valid, first_multiple, last_multiple, in_ready, busy} !== 5'b10110) $display("FAIL lm_flags2 got %b want 10110", {out_valid, first_multiple, last_multiple, in_ready, busy}); else passCnt++;
      step();
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL lm_end got %b want 0", out_valid); else passCnt++;
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_ir = 16'h640E;
      step();
      in_valid = 1'b0;
      totalCnt++; if ({out_ir, first_multiple} !== {16'h4280, 1'b1}) $display("FAIL defer_op0 got %h/%b want 4280/1", out_ir, first_multiple); else passCnt++;
      step();
      totalCnt++; if ({out_ir, first_multiple, last_multiple} !== {16'h4682, 2'b00}) $display("FAIL defer_op1 got %h/%b%b want 4682/00", out_ir, first_multiple, last_multiple); else passCnt++;
      step();
      totalCnt++; if ({out_ir, last_multiple, in_ready} !== {16'h4481, 2'b11}) $display("FAIL defer_op2 got %h/%b%b want 4481/11", out_ir, last_multiple, in_ready); else passCnt++;
      in_valid = 1'b1; in_ir = 16'h7081;
      step();
      in_valid = 1'b0;
      totalCnt++; if ({out_valid, out_ir, first_multiple} !== {1'b1, 16'h5000, 1'b1}) $display("FAIL b2b_op got %b/%h/%b want 1/5000/1", out_valid, out_ir, first_multiple); else passCnt++;
      step();
      totalCnt++; if ({out_ir, last_multiple} !== {16'h5E01, 1'b1}) $display("FAIL b2b_last got %h/%b want 5e01/1", out_ir, last_multiple); else passCnt++;
      step();
   endtask

   task automatic test_sm_hold();
      in_valid = 1'b1; in_ir = 16'h7081;
      step();
      in_valid = 1'b0; hold = 1'b1;
      totalCnt++; if ({out_ir, first_multiple} !== {16'h5000, 1'b1}) $display("FAIL sm_op0 got %h/%b want 5000/1", out_ir, first_multiple); else passCnt++;
      totalCnt++; if (in_ready !== 1'b0) $display("FAIL sm_hold_ready got %b want 0", in_ready); else passCnt++;
      step();
      hold = 1'b0;
      totalCnt++; if ({out_valid, out_ir, first_multiple, busy} !== {1'b1, 16'h5000, 2'b11}) $display("FAIL sm_held got %b/%h/%b%b want 1/5000/11", out_valid, out_ir, first_multiple, busy); else passCnt++;
      step();
      totalCnt++; if ({out_ir, first_multiple, last_multiple} !== {16'h5E01, 2'b01}) $display("FAIL sm_op1 got %h/%b%b want 5e01/01", out_ir, first_multiple, last_multiple); else passCnt++;
      step();
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_ir = 16'h6215;
      step();
      in_valid = 1'b0; flush = 1'b1;
      totalCnt++; if (out_ir !== 16'h4040) $display("FAIL flush_pre got %h want 4040", out_ir); else passCnt++;
      step();
      flush = 1'b0;
      totalCnt++; if ({out_valid, out_ir, busy, in_ready} !== {1'b0, 16'h0000, 2'b01}) $display("FAIL flush_out got %b/%h/%b%b want 0/0000/01", out_valid, out_ir, busy, in_ready); else passCnt++;
      for (int i = 0; i < 3; i++) begin
         step();
         totalCnt++; if (out_valid !== 1'b0 || out_ir === 16'h4441) $display("FAIL flush_tail got %b/%h want 0/not 4441", out_valid, out_ir); else passCnt++;
      end
   endtask

   task automatic test_empty_list();
      in_valid = 1'b1; in_ir = 16'h0050;
      step();
      in_ir = 16'h6200;
      step();
      in_valid = 1'b0;
      totalCnt++; if ({out_valid, out_ir, busy, in_ready} !== {1'b0, 16'h0000, 2'b01}) $display("FAIL empty_out got %b/%h/%b%b want 0/0000/01", out_valid, out_ir, busy, in_ready); else passCnt++;
      step();
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1; in_ir = 16'h6215;
      step();
      in_valid = 1'b0;
      step();
      totalCnt++; if (out_ir !== 16'h4441) $display("FAIL ar_pre got %h want 4441", out_ir); else passCnt++;
      #2 reset = 1'b0;
      #1;
      totalCnt++; if ({out_valid, out_ir, first_multiple, last_multiple, busy, in_ready} !== 21'h0) $display("FAIL ar_async got %b/%h/%b%b%b%b want all 0", out_valid, out_ir, first_multiple, last_multiple, busy, in_ready); else passCnt++;
      step();
      reset = 1'b1;
      step();
      totalCnt++; if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL ar_restart got %b want 001", {out_valid, busy, in_ready}); else passCnt++;
      in_valid = 1'b1; in_ir = 16'h0050;
      step();
      in_valid = 1'b0;
      totalCnt++; if ({out_valid, out_ir} !== {1'b1, 16'h0050}) $display("FAIL ar_resume got %b/%h want 1/0050", out_valid, out_ir); else passCnt++;
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lm();
      test_back_to_back();
      test_sm_hold();
      test_flush();
      test_empty_list();
      test_async_reset();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
